// File: rtl/trace_frame_sync_pkg.sv
// Shared constants and state encoding for the TPIU trace frame synchroniser.
package trace_frame_sync_pkg;
  localparam int unsigned HW_W     = 16;
  localparam int unsigned FRAME_HW = 8;
  localparam int unsigned FRAME_W  = HW_W * FRAME_HW;
  localparam int unsigned IDX_W    = $clog2(FRAME_HW);

  localparam logic [HW_W-1:0] SYNC_HALF      = 16'h7FFF;
  localparam logic [HW_W-1:0] SYNC_FULL_TAIL = 16'hFFFF;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    HUNT_7F = 2'd1,
    SYNC    = 2'd2,
    SYNC_7F = 2'd3
  } sync_state_e;
endpackage

// File: rtl/trace_frame_sync_frame_out_buf.sv
// Single-entry output frame buffer with drop-on-full overflow reporting.
module frame_out_buf
  import trace_frame_sync_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] din_i,
  input  logic               ready_i,
  output logic [FRAME_W-1:0] frame_o,
  output logic               valid_o,
  output logic               ovf_pulse_o,
  output logic [7:0]         ovf_count_o
);
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               xfer;

  always_comb begin
    frame_d = frame_q;
    valid_d = valid_q;
    ovf_d   = 1'b0;
    cnt_d   = cnt_q;
    xfer    = valid_q & ready_i;
    if (xfer) valid_d = 1'b0;
    if (load_i) begin
      // A slot freed by this cycle's transfer can take the new frame directly.
      if (!valid_q || xfer) begin
        frame_d = din_i;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      frame_q <= frame_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign frame_o     = frame_q;
  assign valid_o     = valid_q;
  assign ovf_pulse_o = ovf_q;
  assign ovf_count_o = cnt_q;
endmodule

// File: rtl/trace_frame_sync.sv
// TPIU frame synchroniser: hunts for 7FFF/FFFF full sync, assembles 8-halfword frames.
module trace_frame_sync
  import trace_frame_sync_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [HW_W-1:0]    hwIn,
  input  logic               hwValid,
  output logic [FRAME_W-1:0] frame,
  output logic               frameValid,
  input  logic               frameReady,
  output logic               synced,
  output logic               ovfPulse,
  output logic [7:0]         ovfCount
);
  localparam logic [8:0] TO_LIM = 9'(SYNC_TIMEOUT);

  sync_state_e        state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         to_cnt_q, to_cnt_d;
  logic [FRAME_W-1:0] asm_q, asm_d;
  logic               store, complete;
  logic [FRAME_W-1:0] done_frame;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    to_cnt_d   = to_cnt_q;
    asm_d      = asm_q;
    store      = 1'b0;
    complete   = 1'b0;
    done_frame = {hwIn, asm_q[FRAME_W-HW_W-1:0]};
    if (hwValid) begin
      unique case (state_q)
        HUNT:    if (hwIn == SYNC_HALF) state_d = HUNT_7F;
        HUNT_7F: begin
          if (hwIn == SYNC_FULL_TAIL) begin
            state_d  = SYNC;
            idx_d    = '0;
            to_cnt_d = '0;
          end else if (hwIn != SYNC_HALF) begin
            state_d = HUNT;
          end
        end
        SYNC, SYNC_7F: begin
          if (state_q == SYNC_7F && hwIn == SYNC_FULL_TAIL) begin
            state_d  = SYNC;
            idx_d    = '0;
            to_cnt_d = '0;
          end else if (hwIn == SYNC_HALF) begin
            // A lone held 7FFF is dropped when anything but FFFF follows it.
            state_d = SYNC_7F;
          end else begin
            state_d = SYNC;
            store   = !(hwIn == SYNC_FULL_TAIL && idx_q == '0);
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (store) begin
      asm_d[{idx_q, 4'b0} +: HW_W] = hwIn;
      idx_d = idx_q + 1'b1;
      if (idx_q == IDX_W'(FRAME_HW - 1)) begin
        complete = 1'b1;
        to_cnt_d = to_cnt_q + 8'd1;
        if (({1'b0, to_cnt_q} + 9'd1) >= TO_LIM) begin
          state_d  = HUNT;
          idx_d    = '0;
          to_cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      idx_q    <= '0;
      to_cnt_q <= '0;
      asm_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      to_cnt_q <= to_cnt_d;
      asm_q    <= asm_d;
    end
  end

  assign synced = (state_q == SYNC) || (state_q == SYNC_7F);

  frame_out_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .load_i      (complete),
    .din_i       (done_frame),
    .ready_i     (frameReady),
    .frame_o     (frame),
    .valid_o     (frameValid),
    .ovf_pulse_o (ovfPulse),
    .ovf_count_o (ovfCount)
  );
endmodule

// File: tb/tb_trace_frame_sync.sv
// Directed bench for trace_frame_sync; a second instance runs with a short sync timeout.
module tb_trace_frame_sync;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  hwIn = '0;
  logic         hwValid = 1'b0;
  logic         frameReady = 1'b1;
  logic [127:0] frame, frame2;
  logic         frameValid, frameValid2;
  logic         synced, synced2;
  logic         ovfPulse, ovfPulse2;
  logic [7:0]   ovfCount, ovfCount2;

  int npass = 0;
  int ntot  = 0;
  int nfr   = 0;
  int nfr2  = 0;
  logic [127:0] last_fr = '0;

  always #5 clk = ~clk;

  trace_frame_sync #(.SYNC_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .hwIn(hwIn), .hwValid(hwValid),
    .frame(frame), .frameValid(frameValid), .frameReady(frameReady),
    .synced(synced), .ovfPulse(ovfPulse), .ovfCount(ovfCount)
  );

  trace_frame_sync #(.SYNC_TIMEOUT(2)) dut_to (
    .clk(clk), .rst(rst), .hwIn(hwIn), .hwValid(hwValid),
    .frame(frame2), .frameValid(frameValid2), .frameReady(frameReady),
    .synced(synced2), .ovfPulse(ovfPulse2), .ovfCount(ovfCount2)
  );

  always @(posedge clk) begin
    if (!rst && frameValid && frameReady) begin
      nfr++;
      last_fr = frame;
    end
    if (!rst && frameValid2 && frameReady) nfr2++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send(input logic [15:0] h);
    hwIn = h;
    hwValid = 1'b1;
    @(posedge clk);
    #1;
    hwValid = 1'b0;
  endtask

  task automatic send8(input logic [127:0] f);
    for (int k = 0; k < 8; k++) send(f[16*k +: 16]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n0;
    logic [15:0]  w;
    logic [127:0] f;

    // reset state
    idle(2);
    chk("rst_fv", frameValid, 0);
    chk("rst_frame", frame, 0);
    chk("rst_synced", synced, 0);
    chk("rst_ovfp", ovfPulse, 0);
    chk("rst_ovfc", ovfCount, 0);
    rst = 1'b0;
    idle(1);

    // basic sync with padding, one frame
    n0 = nfr;
    send(16'haa55); send(16'haa55); send(16'h0123); send(16'h0123); send(16'h7fff);
    chk("hunt_synced", synced, 0);
    send(16'hffff);
    chk("sync_synced", synced, 1);
    send(16'hffff); send(16'hffff);
    send8(128'hcdef89ab45670123cdef89ab45670123);
    chk("f1_valid", frameValid, 1);
    chk("f1_frame", frame, 128'hcdef89ab45670123cdef89ab45670123);
    idle(2);
    chk("f1_count", nfr - n0, 1);
    chk("f1_drained", frameValid, 0);

    // resync discards partial; index resumes at 1
    n0 = nfr;
    send(16'h0123); send(16'h7fff); send(16'hffff); send(16'hffff); send(16'hffff); send(16'h0123);
    chk("resync_nofr", frameValid, 0);
    chk("resync_synced", synced, 1);
    for (int k = 1; k < 8; k++) send(16'h1111 * 16'(k));
    chk("resync_valid", frameValid, 1);
    chk("resync_frame", frame, 128'h7777_6666_5555_4444_3333_2222_1111_0123);
    idle(1);
    chk("resync_count", nfr - n0, 1);

    // half-sync at index 3 is padding
    send(16'haaaa); send(16'hbbbb); send(16'hcccc); send(16'h7fff);
    chk("half_synced", synced, 1);
    send(16'h1234);
    send(16'h0005); send(16'h0006); send(16'h0007); send(16'h0008);
    chk("half_frame", frame, 128'h0008_0007_0006_0005_1234_cccc_bbbb_aaaa);
    idle(1);

    // overflow with stalled consumer
    frameReady = 1'b0;
    send8(128'h1007_1006_1005_1004_1003_1002_1001_1000);
    chk("ovf_a_valid", frameValid, 1);
    chk("ovf_a_pulse", ovfPulse, 0);
    send8(128'h2007_2006_2005_2004_2003_2002_2001_2000);
    chk("ovf_b_pulse", ovfPulse, 1);
    chk("ovf_b_count", ovfCount, 1);
    chk("ovf_b_hold", frame, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
    idle(1);
    chk("ovf_pulse_once", ovfPulse, 0);
    chk("ovf_valid_hold", frameValid, 1);
    frameReady = 1'b1;
    idle(1);
    chk("ovf_a_xfer", last_fr, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
    chk("ovf_drained", frameValid, 0);
    frameReady = 1'b0;
    send8({8{16'h4444}});
    for (int i = 0; i < 300; i++) begin
      send(16'h7fff); send(16'hffff);
      w = 16'h3000 + 16'(i);
      send8({8{w}});
    end
    chk("ovf_sat", ovfCount, 255);
    chk("ovf_sat_hold", frame, {8{16'h4444}});

    // completion coinciding with transfer
    send(16'h7fff); send(16'hffff);
    f = 128'h5007_5006_5005_5004_5003_5002_5001_5000;
    for (int k = 0; k < 7; k++) send(f[16*k +: 16]);
    frameReady = 1'b1;
    send(f[127:112]);
    chk("coin_valid", frameValid, 1);
    chk("coin_frame", frame, f);
    chk("coin_nopulse", ovfPulse, 0);
    chk("coin_prev", last_fr, {8{16'h4444}});
    idle(1);
    chk("coin_xfer", last_fr, f);

    // async reset mid-frame with a buffered frame
    frameReady = 1'b0;
    send(16'h7fff); send(16'hffff);
    send8({8{16'h6666}});
    chk("ar_pre_valid", frameValid, 1);
    send(16'h0a0a); send(16'h0a0a); send(16'h0a0a);
    #3 rst = 1'b1;
    #1;
    chk("ar_fv", frameValid, 0);
    chk("ar_frame", frame, 0);
    chk("ar_synced", synced, 0);
    chk("ar_ovfc", ovfCount, 0);
    chk("ar_ovfp", ovfPulse, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    frameReady = 1'b1;
    send8(128'h0b07_0b06_0b05_0b04_0b03_0b02_0b01_0b00);
    chk("ar_nosync_fv", frameValid, 0);
    chk("ar_nosync_synced", synced, 0);
    send(16'h7fff); send(16'hffff);
    send8(128'h0c07_0c06_0c05_0c04_0c03_0c02_0c01_0c00);
    chk("ar_resume", frame, 128'h0c07_0c06_0c05_0c04_0c03_0c02_0c01_0c00);
    idle(1);

    // sync timeout on the SYNC_TIMEOUT=2 instance
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    frameReady = 1'b1;
    idle(1);
    n0 = nfr2;
    send(16'h7fff); send(16'hffff);
    send8({8{16'h0d01}});
    chk("to_f1", frame2, {8{16'h0d01}});
    chk("to_f1_synced", synced2, 1);
    send8({8{16'h0d02}});
    chk("to_f2", frame2, {8{16'h0d02}});
    chk("to_f2_valid", frameValid2, 1);
    chk("to_lost", synced2, 0);
    send8({8{16'h0d03}});
    idle(2);
    chk("to_count", nfr2 - n0, 2);
    chk("to_f3_none", frameValid2, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
